// File: rtl/riscv_pkg.sv
// Shared RISC-V decode types: immediate format encoding and major opcodes.
package riscv_pkg;

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5
  } imm_fmt_e;

  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;

endpackage

// File: rtl/imm_extract.sv
// Combinational immediate extractor: opcode -> format class, then the
// format's bit scatter sign-extended from instr[31] to XLEN.
module imm_extract
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm,
  output imm_fmt_e        fmt,
  output logic            illegal
);

  logic [6:0]  opcode_s;
  logic [31:0] imm32_s;

  assign opcode_s = instr[6:0];

  // Classify the opcode; the *-32 opcodes only exist on RV64.
  always_comb begin
    fmt     = FMT_NONE;
    illegal = 1'b0;
    case (opcode_s)
      OPC_LOAD, OPC_OP_IMM, OPC_JALR, OPC_SYSTEM: fmt = FMT_I;
      OPC_STORE:            fmt = FMT_S;
      OPC_BRANCH:           fmt = FMT_B;
      OPC_LUI, OPC_AUIPC:   fmt = FMT_U;
      OPC_JAL:              fmt = FMT_J;
      OPC_OP:               fmt = FMT_NONE;
      OPC_OP_IMM_32: begin
        if (XLEN == 64) fmt = FMT_I;
        else            illegal = 1'b1;
      end
      OPC_OP_32: begin
        if (XLEN == 64) fmt = FMT_NONE;
        else            illegal = 1'b1;
      end
      default:              illegal = 1'b1;
    endcase
  end

  // Gather the immediate bits for the chosen format, sign-extended to 32 bits.
  always_comb begin
    imm32_s = 32'd0;
    case (fmt)
      FMT_I:   imm32_s = {{20{instr[31]}}, instr[31:20]};
      FMT_S:   imm32_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      FMT_B:   imm32_s = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      FMT_U:   imm32_s = {instr[31:12], 12'd0};
      FMT_J:   imm32_s = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm32_s = 32'd0;
    endcase
  end

  // Widen to XLEN; on RV64 bit 31 (including U-type) extends upward.
  if (XLEN == 64) begin : g_rv64
    assign imm = {{32{imm32_s[31]}}, imm32_s};
  end else begin : g_rv32
    assign imm = imm32_s;
  end

endmodule

// File: rtl/imm_decode_stage.sv
// Registered immediate-decode pipeline stage with valid/ready handshake,
// optional 2-entry skid buffer, flush, and saturating illegal-opcode counter.
module imm_decode_stage
  import riscv_pkg::*;
#(
  parameter int XLEN          = 32,
  parameter int SKID          = 0,
  parameter int ILLEGAL_CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_instr,
  input  logic [XLEN-1:0]          in_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [XLEN-1:0]          out_imm,
  output logic [2:0]               out_fmt,
  output logic [XLEN-1:0]          out_pc,
  output logic                     out_illegal,
  output logic [ILLEGAL_CNT_W-1:0] illegal_count
);

  logic [XLEN-1:0]          dec_imm_s;
  imm_fmt_e                 dec_fmt_s;
  logic                     dec_illegal_s;

  logic                     main_valid_r;
  logic [XLEN-1:0]          main_imm_r;
  imm_fmt_e                 main_fmt_r;
  logic [XLEN-1:0]          main_pc_r;
  logic                     main_illegal_r;

  logic                     skid_valid_r;
  logic [XLEN-1:0]          skid_imm_r;
  imm_fmt_e                 skid_fmt_r;
  logic [XLEN-1:0]          skid_pc_r;
  logic                     skid_illegal_r;

  logic [ILLEGAL_CNT_W-1:0] count_r;
  logic                     in_ready_s;
  logic                     accept_s;
  logic                     pop_s;

  imm_extract #(.XLEN(XLEN)) u_imm_extract (
    .instr   (in_instr),
    .imm     (dec_imm_s),
    .fmt     (dec_fmt_s),
    .illegal (dec_illegal_s)
  );

  // Handshake: skid mode only looks at registered skid occupancy, so in_ready
  // has no combinational path from out_ready.
  always_comb begin
    pop_s = main_valid_r & out_ready;
    if (SKID != 0) begin
      in_ready_s = ~rst & ~flush & ~skid_valid_r;
    end else begin
      in_ready_s = ~rst & ~flush & (~main_valid_r | out_ready);
    end
    accept_s = in_valid & in_ready_s;
  end

  // Main/skid entry registers; skid drains into main first to keep FIFO order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_valid_r   <= 1'b0;
      main_imm_r     <= '0;
      main_fmt_r     <= FMT_NONE;
      main_pc_r      <= '0;
      main_illegal_r <= 1'b0;
      skid_valid_r   <= 1'b0;
      skid_imm_r     <= '0;
      skid_fmt_r     <= FMT_NONE;
      skid_pc_r      <= '0;
      skid_illegal_r <= 1'b0;
    end else if (flush) begin
      main_valid_r <= 1'b0;
      skid_valid_r <= 1'b0;
    end else if (pop_s && skid_valid_r) begin
      main_valid_r   <= 1'b1;
      main_imm_r     <= skid_imm_r;
      main_fmt_r     <= skid_fmt_r;
      main_pc_r      <= skid_pc_r;
      main_illegal_r <= skid_illegal_r;
      skid_valid_r   <= 1'b0;
    end else if (accept_s && (!main_valid_r || pop_s)) begin
      main_valid_r   <= 1'b1;
      main_imm_r     <= dec_imm_s;
      main_fmt_r     <= dec_fmt_s;
      main_pc_r      <= in_pc;
      main_illegal_r <= dec_illegal_s;
    end else if (accept_s) begin
      skid_valid_r   <= 1'b1;
      skid_imm_r     <= dec_imm_s;
      skid_fmt_r     <= dec_fmt_s;
      skid_pc_r      <= in_pc;
      skid_illegal_r <= dec_illegal_s;
    end else if (pop_s) begin
      main_valid_r <= 1'b0;
    end
  end

  // Saturating count of accepted illegal instructions; flush blocks accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r <= '0;
    end else if (accept_s && dec_illegal_s && (count_r != {ILLEGAL_CNT_W{1'b1}})) begin
      count_r <= count_r + ILLEGAL_CNT_W'(1);
    end
  end

  assign in_ready      = in_ready_s;
  assign out_valid     = main_valid_r;
  assign out_imm       = main_imm_r;
  assign out_fmt       = main_fmt_r;
  assign out_pc        = main_pc_r;
  assign out_illegal   = main_illegal_r;
  assign illegal_count = count_r;

endmodule
